// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over a shared memory port and generates all datapath selects/strobes.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_JAL,
    S_ALUWB,
    S_BEQ
  } state_t;

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  // NOTE: every output and the next state get a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;

    unique case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            illegal_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        // Only lw/sw reach here; op[5] tells the store apart.
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        // Link value OldPC+4 goes to ALUOut; PC takes the target held in ALUOut.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b00;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc     = 2'b00;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b01;
        ResultSrc  = 2'b00;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write strobes are gated by reset_n so nothing is written while reset is held.
  assign IRWrite       = reset_n & ir_write_raw;
  assign MemWrite      = reset_n & mem_write_raw;
  assign RegWrite      = reset_n & reg_write_raw;
  assign illegal_instr = reset_n & illegal_raw;
  assign PCWrite       = reset_n & (pc_update | (branch & Zero));

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: builds the expected per-cycle output trace of each
// instruction from its class and wait counts, and compares cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_t;

  typedef struct {
    logic        rdy;
    logic [17:0] exp;
    string       tag;
  } step_t;

  step_t      q[$];
  logic [1:0] m_imm;
  int         errors = 0;
  int         checks = 0;

  wire [17:0] obs = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input logic req, input logic adr, input logic mw,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] ac,
                                     input logic ill);
    return {req, adr, mw, irw, pcw, rw, rs, sa, sb, m_imm, ac, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation an R-type or I-ALU instruction is expected to request.
  function automatic logic [2:0] exec_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (is_r && f7) ? SUB : ADD;
    if (f3 == 3'b010) return SLT;
    if (f3 == 3'b110) return OR_;
    if (f3 == 3'b111) return AND_;
    return ADD;
  endfunction

  task automatic push(input logic rdy, input logic [17:0] e, input string tag);
    step_t s;
    s.rdy = rdy;
    s.exp = e;
    s.tag = tag;
    q.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction from its class and the memory wait counts.
  task automatic build(input kind_t k, input logic [2:0] f3, input logic f7,
                       input logic z, input int wf, input int wm);
    logic [17:0] e;
    for (int i = 0; i < wf; i++) push(1'b0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0), "fetch_wait");
    push(1'b1, mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,ADD,0), "fetch");
    push(rnd_bit(), mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,ADD,(k == K_ILL)), "decode");
    case (k)
      K_LW: begin
        push(rnd_bit(), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0), "memadr");
        e = mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,ADD,0);
        for (int i = 0; i < wm; i++) push(1'b0, e, "memread_wait");
        push(1'b1, e, "memread");
        push(rnd_bit(), mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,ADD,0), "memwb");
      end
      K_SW: begin
        push(rnd_bit(), mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0), "memadr");
        e = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,ADD,0);
        for (int i = 0; i < wm; i++) push(1'b0, e, "memwrite_wait");
        push(1'b1, e, "memwrite");
      end
      K_R, K_I: begin
        push(rnd_bit(), mk(0,0,0,0,0,0,2'b00,2'b10,(k == K_R) ? 2'b00 : 2'b01,
                           exec_alu(k == K_R, f3, f7),0), "execute");
        push(rnd_bit(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "aluwb");
      end
      K_JAL: begin
        push(rnd_bit(), mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,ADD,0), "jal");
        push(rnd_bit(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "aluwb");
      end
      K_BEQ: push(rnd_bit(), mk(0,0,0,0,z,0,2'b00,2'b10,2'b00,SUB,0), "beq");
      default: ;
    endcase
  endtask

  // Runs queued cycles: drive just after a rising edge, check on the falling edge.
  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      check(s.tag, 32'(obs), 32'(s.exp));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] op_of(input kind_t k, input logic [6:0] ill_op);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return ill_op;
    endcase
  endfunction

  task automatic instr(input kind_t k, input logic [2:0] f3, input logic f7, input logic z,
                       input int wf, input int wm, input logic [6:0] ill_op);
    op       = op_of(k, ill_op);
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    m_imm    = imm_of(op);
    build(k, f3, f7, z, wf, wm);
    run_steps(q.size());
  endtask

  logic [6:0] ill_ops [5] = '{7'b1110011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = 7'b0000011;
    funct3    = 3'b000;
    funct7b5  = 1'b0;
    Zero      = 1'b1;
    m_imm     = imm_of(op);

    // Reset held with mem_ready high: FETCH selects, every strobe low.
    #2;
    check("reset_async", 32'(obs), 32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0)));
    @(negedge clk);
    @(negedge clk);
    check("reset_held", 32'(obs), 32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0)));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed: test-plan instructions.
    instr(K_R,   3'b000, 1'b0, 1'b0, 0, 0, 7'd0);
    instr(K_R,   3'b000, 1'b1, 1'b0, 0, 0, 7'd0);
    instr(K_I,   3'b000, 1'b1, 1'b0, 0, 0, 7'd0);
    instr(K_LW,  3'b010, 1'b0, 1'b0, 2, 3, 7'd0);
    instr(K_SW,  3'b010, 1'b0, 1'b0, 0, 2, 7'd0);
    instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 7'd0);
    instr(K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 7'd0);
    instr(K_JAL, 3'b000, 1'b0, 1'b1, 0, 0, 7'd0);
    instr(K_ILL, 3'b000, 1'b0, 1'b0, 0, 0, 7'b1110011);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 6));
      instr(k, 3'($urandom), rnd_bit(), rnd_bit(), $urandom_range(0, 3),
            $urandom_range(0, 3), ill_ops[$urandom_range(0, 4)]);
    end

    // Reset asserted mid-store: strobes drop at once and state returns to FETCH.
    op     = 7'b0100011;
    funct3 = 3'b010;
    m_imm  = imm_of(op);
    build(K_SW, 3'b010, 1'b0, 1'b0, 0, 4);
    run_steps(3);
    begin
      step_t s;
      s = q.pop_front();
      mem_ready = 1'b0;
      @(negedge clk);
      check("sw_before_reset", 32'(obs), 32'(s.exp));
    end
    q.delete();
    #1;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("sw_reset_drop", 32'(obs), 32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0)));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    instr(K_R, 3'b111, 1'b0, 1'b0, 1, 0, 7'd0);
    instr(K_SW, 3'b010, 1'b0, 1'b0, 0, 1, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core variant. The block sequences a shared-memory datapath (single instruction/data memory port, IR, OldPC, A/B/ALUOut/Data holding registers) through fetch, decode, execute, memory and writeback steps. It generates every per-cycle mux select and write strobe, and it stalls on a memory ready handshake.

## Interface
Parameters:
- none. The supported instruction subset and the encodings below are fixed.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12] from IR
- funct7b5  in  1  Instr[30] from IR
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory has read data valid / has accepted the write this cycle
- mem_req  out  1  memory access in progress
- AdrSrc  out  1  0 = PC, 1 = ALUOut, used as memory address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse: unsupported opcode decoded

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- State outputs and next state. Any output not listed is 0 or 00. ALUOp is internal.
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - lw/sw go to MEMADR.
    - R-type goes to EXECUTER.
    - I-ALU goes to EXECUTEI.
    - jal goes to JAL.
    - beq goes to BEQ.
    - Other opcodes pulse illegal_instr and go to FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw goes to MEMREAD, sw goes to MEMWRITE.
  - MEMREAD: mem_req=1, AdrSrc=1. Stay while !mem_ready, else go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
  - MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Hold address and strobe stable until mem_ready, then go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then go to ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is combinational from op in every state:
  - lw/I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - other opcodes → 00
- ALU decoder:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 decodes funct3:
    - 000 → sub if {op[5],funct7b5}==11, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other funct3 → add

## Timing
- Reset (reset_n low, asynchronous):
  - State = FETCH immediately.
  - PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are forced 0 while reset_n is low.
  - Other outputs take their FETCH values.
- Reset deassertion takes effect at the first rising edge with reset_n high.
- Reset mid-instruction abandons the instruction. No partial write occurs after reset_n falls.
- Cycle counts with zero wait states:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in all other states.
- MemWrite and AdrSrc are Moore outputs: constant for every cycle of MEMWRITE.
- IRWrite, PCWrite (FETCH) and PCWrite (BEQ) are combinational from mem_ready/Zero in the same cycle.
- The datapath samples all strobes on the next rising edge.
- illegal_instr is high exactly one cycle (the DECODE cycle). The PC has already advanced by 4.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 → PCWrite=IRWrite=MemWrite=RegWrite=0, ALUSrcB=10. Release reset_n → the first edge loads IR, and DECODE follows.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB; 4 cycles. With funct7b5=1 → ALUControl=001.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → total 10 cycles; IRWrite high only in the ready cycle; RegWrite with ResultSrc=01 in MEMWB.
- sw with mem_ready low 2 cycles in MEMWRITE → MemWrite=1, AdrSrc=1 for 3 consecutive cycles; no RegWrite; ImmSrc=01.
- beq with Zero=1 → PCWrite=1 in BEQ, ALUControl=001. With Zero=0 → PCWrite=0; 3 cycles either way.
- jal → PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11. Opcode 1110011 → illegal_instr=1 for one cycle, then return to FETCH. reset_n pulsed low in MEMWRITE → MemWrite drops immediately, state=FETCH.
